sync_fifo_ctrl: RTL

Parametrised single-clock FIFO, next generation of the team's synchronous FIFO.
- Adds a first-word-fall-through (FWFT) mode selectable by parameter.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags and a synchronous flush.
- Sits between producer/consumer pipeline stages in the same clock domain. Used as a rate-decoupling buffer and for stream buffering.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_ram_sp.sv | 46 ++++
 rtl/sync_fifo_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO family.
//   FIFO_STD / FIFO_FWFT : values for the FWFT parameter of sync_fifo_ctrl
//   ptr_width()          : read/write pointer width for a given depth
//                          (address bits plus one wrap bit)
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_sp.sv
// ----------------------------------------------------------------------------
// fifo_ram_sp
// Simple dual-port register array: synchronous write, registered read.
// Read data updates only on i_rd_en and otherwise holds its last value.
// A read and a write to the same address in one cycle return the old word.
// Ports:
//   i_clk, i_rstn           clock, synchronous active-low reset (read reg only)
//   i_wr_en/addr/data       write port
//   i_rd_en/addr            read port
//   o_rd_data               registered read data
// ----------------------------------------------------------------------------
module fifo_ram_sp #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DWIDTH-1:0] o_rd_data
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// sync_fifo_ctrl
// Single-clock FIFO with standard (1-cycle read latency) or first-word-
// fall-through output, occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and synchronous flush.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   flush, clr_err       empty the FIFO / clear the sticky error flags
//   wr_en, din           write request and data
//   rd_en                read request (FWFT: acknowledge of dout)
//   dout, dout_valid     read data and its qualifier
//   empty, full          count == 0 / count == DEPTH
//   almost_full/empty    count >= AFULL_THRESH / count <= AEMPTY_THRESH
//   count                words held, 0..DEPTH
//   overflow, underflow  sticky error flags
// ----------------------------------------------------------------------------
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DWIDTH        = 16,
    parameter int DEPTH         = 8,
    parameter int FWFT          = FIFO_STD,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int CW            = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              clr_err,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] din,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic IS_FWFT = (FWFT == FIFO_FWFT);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_err_depth
        $error("sync_fifo_ctrl: DEPTH must be a power of two >= 2");
    end
    if (AFULL_THRESH > DEPTH) begin : g_err_afull
        $error("sync_fifo_ctrl: AFULL_THRESH must not exceed DEPTH");
    end
    if (AEMPTY_THRESH >= DEPTH) begin : g_err_aempty
        $error("sync_fifo_ctrl: AEMPTY_THRESH must be below DEPTH");
    end

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_dv;
    logic              r_ovf;
    logic              r_udf;
    logic              r_byp_sel;
    logic [DWIDTH-1:0] r_byp_data;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_ram_has;
    logic              w_fill;
    logic              w_bypass;
    logic              w_ram_wr;
    logic              w_ram_rd;
    logic              w_ovf_evt;
    logic              w_udf_evt;
    logic [DWIDTH-1:0] w_ram_rd_data;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == DEPTH_C);
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    // In FWFT mode the head word sits in the RAM read register (or the bypass
    // register), so the RAM pointers only span the words behind the head.
    assign w_ram_has = (r_wr_ptr != r_rd_ptr);
    assign w_fill    = w_empty | w_rd_acc;
    // A word written while nothing else is queued goes straight to the output
    // register; going through the RAM would cost an extra cycle.
    assign w_bypass  = IS_FWFT & w_fill & ~w_ram_has & w_wr_acc;

    assign w_ram_wr = rstn & ~flush & w_wr_acc & ~w_bypass;
    assign w_ram_rd = rstn & ~flush & (IS_FWFT ? (w_fill & w_ram_has) : w_rd_acc);

    assign w_ovf_evt = wr_en & w_full & ~w_rd_acc;
    assign w_udf_evt = rd_en & w_empty;

    fifo_ram_sp #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_wr_en   (w_ram_wr),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (din),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_ram_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dv       <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_byp_sel  <= 1'b0;
            r_byp_data <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dv     <= 1'b0;
            r_ovf    <= r_ovf & ~clr_err;
            r_udf    <= r_udf & ~clr_err;
        end else begin
            if (w_ram_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_dv <= w_rd_acc;
            if (w_bypass) begin
                r_byp_sel  <= 1'b1;
                r_byp_data <= din;
            end else if (w_ram_rd) begin
                r_byp_sel  <= 1'b0;
            end
            // A set event wins over a simultaneous clear.
            r_ovf <= w_ovf_evt | (r_ovf & ~clr_err);
            r_udf <= w_udf_evt | (r_udf & ~clr_err);
        end
    end

    assign dout         = (IS_FWFT && r_byp_sel) ? r_byp_data : w_ram_rd_data;
    assign dout_valid   = IS_FWFT ? ~w_empty : r_dv;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
